pwm_bank: RTL and testbench
===========================

# pwm_bank

Multi-channel PWM generator that replaces the single-channel LED PWM in the LED brightness path. It drives `CHANNELS` outputs from one shared period counter. Each channel has its own target duty, clamped to a parametrised brightness window. A channel either jumps to a new duty or ramps (fades) to it by a fixed step per PWM period. Duty changes take effect only at period boundaries, so no output ever produces a runt pulse.

## Interface
Parameters:
- `CHANNELS` — default 4 — number of PWM outputs, ≥1.
- `WIDTH` — default `BRIGHTNESS_WIDTH` — counter and duty width; period is 2^WIDTH cycles.
- `MIN_DUTY` — default `(2**WIDTH-1)*LED_MIN_BRIGHTNESS/100` — lower clamp on the written duty.
- `MAX_DUTY` — default `(2**WIDTH-1)*LED_MAX_BRIGHTNESS/100` — upper clamp; `MIN_DUTY ≤ MAX_DUTY` is required.
- `RAMP_STEP` — default 1 — duty codes moved per period in ramp mode, ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `sysclk` — in — 1 — system clock.
- `i_rst_n` — in — 1 — asynchronous active-low reset.
- `i_enb` — in — 1 — global enable.
- `i_wr` — in — 1 — write strobe for one channel's target.
- `i_ch` — in — `$clog2(CHANNELS)` (min 1) — channel index; writes with index ≥ `CHANNELS` are ignored.
- `i_duty` — in — WIDTH — requested duty.
- `i_ramp` — in — 1 — mode latched with the write: 1 = ramp, 0 = jump.
- `o_pwm` — out — CHANNELS — PWM outputs, registered.
- `o_cnt` — out — WIDTH — shared period counter, registered.
- `o_busy` — out — CHANNELS — high while a channel's active duty differs from its target.
- `o_wrap` — out — 1 — one-cycle pulse marking the first cycle of each period.

## Operation
- Reset values: `o_cnt` = all ones, `o_pwm` = 0, `o_busy` = 0, `o_wrap` = 0; per channel, target = active = `MIN_DUTY` and ramp mode = 0.
- Write: on `i_wr`, the channel's target is set to the clamped value `min(max(i_duty, MIN_DUTY), MAX_DUTY)` and its mode is set to `i_ramp`. Writes are accepted whether or not `i_enb` is high. A later write overrides an earlier one.
- Counter with `i_enb` = 1: `o_cnt` increments and wraps from 2^WIDTH-1 to 0.
- Counter with `i_enb` = 0: `o_cnt` is forced to all ones and `o_pwm` is forced to 0. Targets and active duties are retained; ramps make no progress.
- Boundary: the cycle where `i_enb` = 1 and `o_cnt` = 2^WIDTH-1. At that edge each channel updates its active duty:
  - jump mode: active = target;
  - ramp mode: active moves toward target by `RAMP_STEP`, saturating exactly at target with no overshoot.
- Write during the boundary cycle: the new target and mode are used for that boundary update (write bypass).
- Compare: `o_pwm[k]` = 1 when the next counter value is less than the next active duty of channel k. This keeps `o_pwm` aligned with `o_cnt` in the same cycle.
  - Duty 0 gives a constant low output.
  - Duty 2^WIDTH-1 gives high for 2^WIDTH-1 of every 2^WIDTH cycles.
- `o_busy[k]` is registered, equal to (active ≠ target), and updates the cycle after any write or boundary.
- `o_wrap` = 1 exactly in the cycles where `o_cnt` = 0 while enabled.
- Reset asserted mid-period: all state is cleared immediately. Release takes effect on the first `sysclk` edge after `i_rst_n` is synchronously deasserted upstream.

## Timing
- Write to visible target and `o_busy`: 1 cycle.
- Write to first use of the new duty: the period whose first cycle (`o_cnt` = 0) follows the next boundary.
- Re-enable from disabled: the first enabled cycle is a boundary, so `o_cnt` = 0, `o_wrap` = 1 and the updated duty all appear together on the next cycle.
- Ramp from a to b: |b-a|/`RAMP_STEP` periods, rounded up; `o_busy` falls in the cycle after the final boundary.

## Structure
- `BRIGHTNESS_WIDTH`, `LED_MIN_BRIGHTNESS` and `LED_MAX_BRIGHTNESS` stay in `params.vh`. Add `PWM_CHANNELS` and `PWM_RAMP_STEP` there as the defaults.
- Sub-module `pwm_bank_ch`: per-channel target, mode and active registers, clamp, ramp step, compare and busy flag.
- The top level holds the shared counter, boundary/wrap generation, write decode, and a generate loop over `CHANNELS`.

## Test plan
All scenarios use WIDTH=4, MIN=2, MAX=13, STEP=1, CHANNELS=4.
- Reset then enable: `o_cnt` sequence 15 → 0 → 1 …; `o_wrap` pulses every 16 cycles; all `o_pwm` high for 2 of every 16 cycles (MIN clamp).
- Jump write ch1 = 8 mid-period: `o_busy[1]` = 1 one cycle later; the next period shows exactly 8 high cycles at `o_cnt` 0..7; `o_busy[1]` clears after the boundary.
- Clamp: write ch2 = 0 gives 2 high cycles per period; write ch2 = 15 gives 13 high cycles per period.
- Ramp ch3 from 2 to 6: high counts over the following periods are 3, 4, 5, 6; `o_busy[3]` deasserts after the 4th boundary.
- Boundary bypass and disable: a write of ch0 = 10 at `o_cnt` = 15 is used in the immediately following period. Dropping `i_enb` gives `o_cnt` = 15 and `o_pwm` = 0 on the next cycle; re-enable starts cleanly at 0.
- Async reset: asserting `i_rst_n` = 0 mid-ramp clears outputs without waiting for a clock edge; after release all channels are back at duty 2.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared defaults and types for the multi-channel LED PWM bank.
// The brightness defaults live here so every PWM user sees one set of values.
package pwm_bank_pkg;

  localparam int BRIGHTNESS_WIDTH   = 8;
  localparam int LED_MIN_BRIGHTNESS = 5;
  localparam int LED_MAX_BRIGHTNESS = 95;
  localparam int PWM_CHANNELS       = 4;
  localparam int PWM_RAMP_STEP      = 1;

  typedef enum logic {
    MODE_JUMP = 1'b0,
    MODE_RAMP = 1'b1
  } mode_t;

  // Channel index width, never narrower than one bit.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pwm_bank_ch.sv
// One PWM channel: clamped target, jump/ramp mode, active duty updated only at
// period boundaries, registered compare output and busy flag.
module pwm_bank_ch
  import pwm_bank_pkg::*;
#(
  parameter int WIDTH     = BRIGHTNESS_WIDTH,
  parameter int MIN_DUTY  = 0,
  parameter int MAX_DUTY  = 2**WIDTH - 1,
  parameter int RAMP_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             boundary,
  input  logic             wr,
  input  logic [WIDTH-1:0] duty,
  input  logic             ramp,
  input  logic [WIDTH-1:0] cnt_next,
  output logic             pwm,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_D  = WIDTH'(MIN_DUTY);
  localparam logic [WIDTH-1:0] MAX_D  = WIDTH'(MAX_DUTY);
  localparam logic [WIDTH-1:0] STEP_D = WIDTH'(RAMP_STEP);

  logic [WIDTH-1:0] target, target_next;
  logic [WIDTH-1:0] active, active_next;
  logic [WIDTH-1:0] clamped, diff;
  mode_t            mode, mode_next;

  always_comb begin
    clamped = duty;
    if (duty < MIN_D) begin
      clamped = MIN_D;
    end else if (duty > MAX_D) begin
      clamped = MAX_D;
    end
  end

  // A write in the boundary cycle is bypassed straight into that update.
  assign target_next = wr ? clamped : target;
  assign mode_next   = wr ? mode_t'(ramp) : mode;

  always_comb begin
    active_next = active;
    diff        = '0;
    if (boundary) begin
      if (mode_next == MODE_JUMP) begin
        active_next = target_next;
      end else if (active < target_next) begin
        diff        = target_next - active;
        active_next = (int'(diff) > RAMP_STEP) ? active + STEP_D : target_next;
      end else begin
        diff        = active - target_next;
        active_next = (int'(diff) > RAMP_STEP) ? active - STEP_D : target_next;
      end
    end
  end

  // Compare against next-cycle values so pwm lines up with the registered counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= MIN_D;
      mode   <= MODE_JUMP;
      active <= MIN_D;
      pwm    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      target <= target_next;
      mode   <= mode_next;
      active <= active_next;
      pwm    <= enb && (cnt_next < active_next);
      busy   <= (active_next != target_next);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: one shared period counter, boundary/wrap generation
// and write decode feeding a channel instance per output.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter  int CHANNELS  = PWM_CHANNELS,
  parameter  int WIDTH     = BRIGHTNESS_WIDTH,
  parameter  int MIN_DUTY  = (2**WIDTH - 1) * LED_MIN_BRIGHTNESS / 100,
  parameter  int MAX_DUTY  = (2**WIDTH - 1) * LED_MAX_BRIGHTNESS / 100,
  parameter  int RAMP_STEP = PWM_RAMP_STEP,
  localparam int CH_W      = ch_width(CHANNELS)
) (
  input  logic                sysclk,
  input  logic                i_rst_n,
  input  logic                i_enb,
  input  logic                i_wr,
  input  logic [CH_W-1:0]     i_ch,
  input  logic [WIDTH-1:0]    i_duty,
  input  logic                i_ramp,
  output logic [CHANNELS-1:0] o_pwm,
  output logic [WIDTH-1:0]    o_cnt,
  output logic [CHANNELS-1:0] o_busy,
  output logic                o_wrap
);

  logic [WIDTH-1:0] cnt_next;
  logic             boundary;

  // Disabled parks the counter at all ones, so re-enable starts on a boundary.
  assign boundary = i_enb && (o_cnt == '1);
  assign cnt_next = i_enb ? o_cnt + WIDTH'(1) : '1;

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt  <= '1;
      o_wrap <= 1'b0;
    end else begin
      o_cnt  <= cnt_next;
      o_wrap <= boundary;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic wr_sel;

    // Indices at or beyond CHANNELS match no instance and are dropped.
    assign wr_sel = i_wr && (int'(i_ch) == k);

    pwm_bank_ch #(
      .WIDTH     (WIDTH),
      .MIN_DUTY  (MIN_DUTY),
      .MAX_DUTY  (MAX_DUTY),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk      (sysclk),
      .rst_n    (i_rst_n),
      .enb      (i_enb),
      .boundary (boundary),
      .wr       (wr_sel),
      .duty     (i_duty),
      .ramp     (i_ramp),
      .cnt_next (cnt_next),
      .pwm      (o_pwm[k]),
      .busy     (o_busy[k])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: expected per-period high counts are queued
// when a write is driven and popped when a full period has been observed.
module tb_pwm_bank;

  logic       sysclk;
  logic       i_rst_n;
  logic       i_enb;
  logic       i_wr;
  logic [1:0] i_ch;
  logic [3:0] i_duty;
  logic       i_ramp;
  logic [3:0] o_pwm;
  logic [3:0] o_cnt;
  logic [3:0] o_busy;
  logic       o_wrap;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  pwm_bank #(
    .CHANNELS  (4),
    .WIDTH     (4),
    .MIN_DUTY  (2),
    .MAX_DUTY  (13),
    .RAMP_STEP (1)
  ) dut (
    .sysclk  (sysclk),
    .i_rst_n (i_rst_n),
    .i_enb   (i_enb),
    .i_wr    (i_wr),
    .i_ch    (i_ch),
    .i_duty  (i_duty),
    .i_ramp  (i_ramp),
    .o_pwm   (o_pwm),
    .o_cnt   (o_cnt),
    .o_busy  (o_busy),
    .o_wrap  (o_wrap)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic push_period(input int d0, input int d1, input int d2, input int d3);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(d3);
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [3:0] duty, input logic ramp);
    i_wr   = 1'b1;
    i_ch   = ch;
    i_duty = duty;
    i_ramp = ramp;
    @(negedge sysclk);
    i_wr   = 1'b0;
  endtask

  task automatic wait_cnt(input logic [3:0] value);
    int guard = 0;
    while (o_cnt !== value && guard < 64) begin
      @(negedge sysclk);
      guard++;
    end
    checks++;
    if (o_cnt !== value) begin
      errors++;
      $display("[TB] FAIL wait_cnt got %0d want %0d", o_cnt, value);
    end
  endtask

  // Observes one full period from o_cnt == 0 and compares against the queue.
  task automatic measure_period(output logic [3:0] busy_start);
    int hi[4];
    bit prefix_ok;
    bit seq_ok;
    int want;
    for (int c = 0; c < 4; c++) hi[c] = 0;
    prefix_ok = 1'b1;
    seq_ok    = 1'b1;
    wait_cnt(4'd0);
    busy_start = o_busy;
    for (int i = 0; i < 16; i++) begin
      if (o_cnt !== 4'(i) || o_wrap !== (i == 0)) seq_ok = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (o_pwm[c] === 1'b1) begin
          hi[c]++;
          if (hi[c] != i + 1) prefix_ok = 1'b0;
        end
      end
      @(negedge sysclk);
    end
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("[TB] FAIL period_seq got irregular cnt/wrap want 0..15 with wrap at 0");
    end
    checks++;
    if (!prefix_ok) begin
      errors++;
      $display("[TB] FAIL period_prefix got high cycles not starting at cnt 0 want contiguous from 0");
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_empty ch%0d got %0d want queued value", c, hi[c]);
      end else begin
        want = exp_q.pop_front();
        if (hi[c] !== want) begin
          errors++;
          $display("[TB] FAIL period_high ch%0d got %0d want %0d", c, hi[c], want);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sysclk);
    checks++;
    if (o_cnt !== 4'hF) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 15", o_cnt); end
    checks++;
    if (o_pwm !== 4'h0) begin errors++; $display("[TB] FAIL reset_pwm got %b want 0000", o_pwm); end
    checks++;
    if (o_busy !== 4'h0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0000", o_busy); end
    checks++;
    if (o_wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap got %b want 0", o_wrap); end
    i_rst_n = 1'b1;
    repeat (2) @(negedge sysclk);
    checks++;
    if (o_cnt !== 4'hF) begin errors++; $display("[TB] FAIL idle_cnt got %0d want 15", o_cnt); end
  endtask

  task automatic test_enable();
    logic [3:0] b;
    i_enb = 1'b1;
    @(negedge sysclk);
    checks++;
    if (o_cnt !== 4'h0 || o_wrap !== 1'b1 || o_pwm !== 4'hF) begin
      errors++;
      $display("[TB] FAIL enable_start got cnt %0d wrap %b pwm %b want 0 1 1111", o_cnt, o_wrap, o_pwm);
    end
    push_period(2, 2, 2, 2);
    push_period(2, 2, 2, 2);
    measure_period(b);
    measure_period(b);
    checks++;
    if (b !== 4'h0) begin errors++; $display("[TB] FAIL enable_busy got %b want 0000", b); end
  endtask

  task automatic test_jump();
    logic [3:0] b;
    wait_cnt(4'd4);
    do_write(2'd1, 4'd8, 1'b0);
    checks++;
    if (o_busy !== 4'b0010) begin errors++; $display("[TB] FAIL jump_busy got %b want 0010", o_busy); end
    push_period(2, 8, 2, 2);
    measure_period(b);
    checks++;
    if (b !== 4'h0) begin errors++; $display("[TB] FAIL jump_busy_clear got %b want 0000", b); end
  endtask

  task automatic test_clamp();
    logic [3:0] b;
    wait_cnt(4'd3);
    do_write(2'd2, 4'd0, 1'b0);
    checks++;
    if (o_busy !== 4'b0000) begin errors++; $display("[TB] FAIL clamp_low_busy got %b want 0000", o_busy); end
    push_period(2, 8, 2, 2);
    measure_period(b);
    wait_cnt(4'd3);
    do_write(2'd2, 4'd15, 1'b0);
    checks++;
    if (o_busy !== 4'b0100) begin errors++; $display("[TB] FAIL clamp_high_busy got %b want 0100", o_busy); end
    push_period(2, 8, 13, 2);
    measure_period(b);
  endtask

  task automatic test_ramp();
    logic [3:0] b;
    wait_cnt(4'd4);
    do_write(2'd3, 4'd6, 1'b1);
    checks++;
    if (o_busy !== 4'b1000) begin errors++; $display("[TB] FAIL ramp_busy got %b want 1000", o_busy); end
    for (int d = 3; d <= 6; d++) push_period(2, 8, 13, d);
    for (int p = 0; p < 4; p++) begin
      measure_period(b);
      checks++;
      if (b[3] !== (p < 3)) begin
        errors++;
        $display("[TB] FAIL ramp_busy_p%0d got %b want %b", p, b[3], (p < 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] b;
    wait_cnt(4'd6);
    i_wr = 1'b1; i_ch = 2'd1; i_duty = 4'd12; i_ramp = 1'b0;
    @(negedge sysclk);
    i_duty = 4'd5;
    @(negedge sysclk);
    i_wr = 1'b0;
    checks++;
    if (o_busy !== 4'b0010) begin errors++; $display("[TB] FAIL b2b_busy got %b want 0010", o_busy); end
    wait_cnt(4'd15);
    do_write(2'd0, 4'd10, 1'b0);
    checks++;
    if (o_busy !== 4'b0000) begin errors++; $display("[TB] FAIL bypass_busy got %b want 0000", o_busy); end
    push_period(10, 5, 13, 6);
    measure_period(b);
  endtask

  task automatic test_disable();
    logic [3:0] b;
    wait_cnt(4'd5);
    i_enb = 1'b0;
    @(negedge sysclk);
    checks++;
    if (o_cnt !== 4'hF || o_pwm !== 4'h0 || o_wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL disable got cnt %0d pwm %b wrap %b want 15 0000 0", o_cnt, o_pwm, o_wrap);
    end
    do_write(2'd3, 4'd9, 1'b1);
    repeat (20) @(negedge sysclk);
    checks++;
    if (o_busy !== 4'b1000 || o_cnt !== 4'hF) begin
      errors++;
      $display("[TB] FAIL disable_hold got busy %b cnt %0d want 1000 15", o_busy, o_cnt);
    end
    i_enb = 1'b1;
    @(negedge sysclk);
    checks++;
    if (o_cnt !== 4'h0 || o_wrap !== 1'b1 || o_pwm !== 4'hF) begin
      errors++;
      $display("[TB] FAIL reenable got cnt %0d wrap %b pwm %b want 0 1 1111", o_cnt, o_wrap, o_pwm);
    end
    push_period(10, 5, 13, 7);
    push_period(10, 5, 13, 8);
    push_period(10, 5, 13, 9);
    measure_period(b);
    measure_period(b);
    measure_period(b);
    checks++;
    if (b !== 4'h0) begin errors++; $display("[TB] FAIL reenable_busy got %b want 0000", b); end
  endtask

  task automatic test_async_reset();
    logic [3:0] b;
    wait_cnt(4'd4);
    do_write(2'd3, 4'd13, 1'b1);
    wait_cnt(4'd0);
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_pwm !== 4'h0 || o_cnt !== 4'hF || o_busy !== 4'h0 || o_wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got pwm %b cnt %0d busy %b wrap %b want 0000 15 0000 0",
               o_pwm, o_cnt, o_busy, o_wrap);
    end
    @(negedge sysclk);
    i_rst_n = 1'b1;
    push_period(2, 2, 2, 2);
    measure_period(b);
    checks++;
    if (b !== 4'h0) begin errors++; $display("[TB] FAIL post_reset_busy got %b want 0000", b); end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_enb   = 1'b0;
    i_wr    = 1'b0;
    i_ch    = 2'd0;
    i_duty  = 4'd0;
    i_ramp  = 1'b0;
    test_reset();
    test_enable();
    test_jump();
    test_clamp();
    test_ramp();
    test_back_to_back();
    test_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
